// File: rtl/regfile_check_pkg.sv
// Shared types and helpers for the regfile sweep checker.
package regfile_check_pkg;

   // Engine states.
   typedef enum logic [2:0] {
      StIdle,
      StCrst,
      StRun,
      StSweep,
      StDrain,
      StDone
   } state_e;

   // Cycles the CPU reset pulse is held high.
   localparam int unsigned CPU_RST_CYCLES = 1;

   // Register index width; at least one bit even for a single register.
   function automatic int unsigned reg_aw(input int unsigned num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   // Error counter width: wide enough to count every register mismatching.
   function automatic int unsigned err_w(input int unsigned num_regs);
      return reg_aw(num_regs) + 1;
   endfunction

endpackage

// File: rtl/regfile_sweep_checker_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_clear,
   input  logic             i_enable,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   // Clear wins over enable; increments stop once the counter is full.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/regfile_sweep_checker.sv
// Bring-up self-check: pulse CPU reset, run for a budget, then sweep the regfile vs a ROM.
module regfile_sweep_checker
   import regfile_check_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned CYCLE_W      = 16,
   parameter int unsigned STOP_ON_FAIL = 0,
   parameter int unsigned REG_AW       = reg_aw(NUM_REGS)
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic [CYCLE_W-1:0]    i_num_cycles,
   input  logic                  i_proc_rwe,
   input  logic [REG_AW-1:0]     i_proc_rd,
   output logic                  o_cpu_reset,
   output logic                  o_test_mode,
   output logic [REG_AW-1:0]     o_test_reg,
   input  logic [DATA_WIDTH-1:0] i_reg_data,
   output logic [REG_AW-1:0]     o_exp_addr,
   input  logic [DATA_WIDTH-1:0] i_exp_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic [REG_AW:0]       o_error_count,
   output logic [CYCLE_W-1:0]    o_wr_count,
   output logic                  o_fail_valid,
   output logic [REG_AW-1:0]     o_fail_reg,
   output logic [DATA_WIDTH-1:0] o_fail_exp,
   output logic [DATA_WIDTH-1:0] o_fail_act
);

   state_e                r_state, w_state_next;
   logic [CYCLE_W-1:0]    r_budget;
   logic [3:0]            r_crst_cnt;
   logic [REG_AW-1:0]     r_test_reg;
   logic                  r_cmp_valid;
   logic [REG_AW-1:0]     r_cmp_idx;
   logic [DATA_WIDTH-1:0] r_cmp_act;
   logic [REG_AW:0]       r_err;
   logic                  r_fail_valid;
   logic [REG_AW-1:0]     r_fail_reg;
   logic [DATA_WIDTH-1:0] r_fail_exp;
   logic [DATA_WIDTH-1:0] r_fail_act;
   logic                  r_done;
   logic                  r_pass;

   logic [CYCLE_W-1:0]    w_run_cnt;
   logic                  w_accept;
   logic                  w_mismatch;
   logic                  w_stop;
   logic                  w_last_issue;
   logic                  w_run_last;
   logic                  w_crst_last;
   logic [REG_AW:0]       w_err_next;

   assign w_accept     = i_start && ((r_state == StIdle) || (r_state == StDone));
   // exp_data arrives one cycle after its address, matching the captured reg_data.
   assign w_mismatch   = r_cmp_valid && (i_exp_data != r_cmp_act);
   assign w_stop       = (STOP_ON_FAIL != 0) && w_mismatch;
   assign w_last_issue = (r_test_reg == REG_AW'(NUM_REGS - 1));
   assign w_run_last   = (w_run_cnt == (r_budget - CYCLE_W'(1)));
   assign w_crst_last  = (r_crst_cnt == 4'(CPU_RST_CYCLES - 1));
   assign w_err_next   = r_err + {{REG_AW{1'b0}}, w_mismatch};

   // Cycle counter for the RUN phase.
   sat_counter #(
      .WIDTH(CYCLE_W)
   ) u_run_cnt (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_clear  (w_accept),
      .i_enable (r_state == StRun),
      .o_count  (w_run_cnt)
   );

   // Architectural register writes seen while the CPU runs (r0 writes are discarded).
   sat_counter #(
      .WIDTH(CYCLE_W)
   ) u_wr_cnt (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_clear  (w_accept),
      .i_enable ((r_state == StRun) && i_proc_rwe && (i_proc_rd != '0)),
      .o_count  (o_wr_count)
   );

   // State register.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= StIdle;
      else            r_state <= w_state_next;
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      w_state_next = r_state;
      o_cpu_reset  = 1'b0;
      o_test_mode  = 1'b0;
      o_busy       = 1'b0;
      unique case (r_state)
         StIdle, StDone: begin
            if (w_accept) w_state_next = StCrst;
         end
         StCrst: begin
            o_cpu_reset = 1'b1;
            o_busy      = 1'b1;
            if (w_crst_last) w_state_next = (r_budget == '0) ? StSweep : StRun;
         end
         StRun: begin
            o_busy = 1'b1;
            if (w_run_last) w_state_next = StSweep;
         end
         StSweep: begin
            o_test_mode = 1'b1;
            o_busy      = 1'b1;
            if (w_stop)            w_state_next = StDone;
            else if (w_last_issue) w_state_next = StDrain;
         end
         StDrain: begin
            o_test_mode  = 1'b1;
            o_busy       = 1'b1;
            w_state_next = StDone;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // CPU reset pulse length counter.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)              r_crst_cnt <= '0;
      else if (r_state == StCrst)  r_crst_cnt <= r_crst_cnt + 4'd1;
      else                         r_crst_cnt <= '0;
   end

   // Issue register, compare pipeline, error count and first-fail capture.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_budget     <= '0;
         r_test_reg   <= '0;
         r_cmp_valid  <= 1'b0;
         r_cmp_idx    <= '0;
         r_cmp_act    <= '0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_reg   <= '0;
         r_fail_exp   <= '0;
         r_fail_act   <= '0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else if (w_accept) begin
         r_budget     <= i_num_cycles;
         r_test_reg   <= '0;
         r_cmp_valid  <= 1'b0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_reg   <= '0;
         r_fail_exp   <= '0;
         r_fail_act   <= '0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         r_cmp_valid <= 1'b0;
         if (r_state == StSweep) begin
            // Capture the combinational regfile read alongside the index it belongs to.
            r_cmp_valid <= !w_stop;
            r_cmp_idx   <= r_test_reg;
            r_cmp_act   <= i_reg_data;
            if (!w_stop && !w_last_issue) r_test_reg <= r_test_reg + REG_AW'(1);
         end
         if (w_mismatch) begin
            r_err <= w_err_next;
            if (!r_fail_valid) begin
               r_fail_valid <= 1'b1;
               r_fail_reg   <= r_cmp_idx;
               r_fail_exp   <= i_exp_data;
               r_fail_act   <= r_cmp_act;
            end
         end
         if ((w_state_next == StDone) && (r_state != StDone)) begin
            r_done <= 1'b1;
            r_pass <= (w_err_next == '0);
         end
      end
   end

   assign o_test_reg    = r_test_reg;
   assign o_exp_addr    = r_test_reg;
   assign o_done        = r_done;
   assign o_pass        = r_pass;
   assign o_error_count = r_err;
   assign o_fail_valid  = r_fail_valid;
   assign o_fail_reg    = r_fail_reg;
   assign o_fail_exp    = r_fail_exp;
   assign o_fail_act    = r_fail_act;

endmodule
